register_file_v3: RTL
=====================

REGISTER_FILE_V3 -- requirements
Module: register_file_v3

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NRD, default 2: number of read ports.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 reads as zero and ignores writes.
REQ-005 Parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to matching read ports.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 clear_req  in  1  request a full register sweep to zero; honoured only in READY.
REQ-009 ready  out  1  high when the array is usable; low during the sweep.
REQ-010 rd_addr  in  NRD*ADDR_W  packed read addresses; port k uses slice k.
REQ-011 rd_data  out  NRD*DATA_W  packed read data, combinational from rd_addr.
REQ-012 init_we, init_addr, init_data  in  1/ADDR_W/DATA_W  initialisation write port, highest priority.
REQ-013 wb_we, wb_addr, wb_data  in  1/ADDR_W/DATA_W  write-back port.
REQ-014 wr_conflict  out  1  registered one-cycle pulse: a write-back was dropped because init_we was also high.

Function
REQ-015 The FSM has two states, CLEAR and READY; ready SHALL be 1 exactly in READY.
REQ-016 In CLEAR, a counter clr_idx writes zero to register clr_idx each cycle and increments it, from 0 to DEPTH-1 inclusive.
REQ-017 The cycle that writes DEPTH-1 transitions to READY. The sweep lasts exactly DEPTH cycles; ready rises on the following edge.
REQ-018 In READY, clear_req=1 transitions to CLEAR with clr_idx=0. Writes presented in that same cycle SHALL still be performed.
REQ-019 clear_req in CLEAR is ignored; it does not restart the sweep.
REQ-020 In CLEAR, init_we and wb_we are ignored, and every rd_data slice reads zero.
REQ-021 In READY, if init_we=1, init_data is written to init_addr on the edge.
REQ-022 In READY, if init_we=0 and wb_we=1, wb_data is written to wb_addr on the edge.
REQ-023 If init_we=1 and wb_we=1 in READY, only the init write occurs, whatever the addresses, and wr_conflict is 1 on the next cycle.
REQ-024 With ZERO_REG=1, writes to address 0 are discarded and every read of address 0 returns 0. This also suppresses bypass.
REQ-025 With BYPASS=1 in READY, read port k returns the winning write's data when rd_addr[k] equals the winning write address this cycle; otherwise it returns the array content.
REQ-026 With BYPASS=0, reads return pre-edge array content.
REQ-027 Read ports are independent; any number may address the same register.
REQ-028 Read latency is zero cycles; write-to-read latency is one edge, or zero with bypass.
REQ-029 All addresses are exactly ADDR_W bits wide, so no out-of-range case exists.

Reset
REQ-030 While rst_n=0: state=CLEAR, clr_idx=0, ready=0, wr_conflict=0.
REQ-031 Array contents are not reset directly; the post-reset sweep zeroes them.
REQ-032 Asserting rst_n mid-sweep or mid-operation aborts immediately; a full DEPTH-cycle sweep restarts after deassertion.

Structure
REQ-033 A shared package rf_pkg holds the state enum (CLEAR, READY) and default parameter constants (DATA_W, ADDR_W, NRD).
REQ-034 One sub-module, rf_clear_seq, contains the FSM and clr_idx counter and outputs ready, clr_we and clr_addr.
REQ-035 The top level holds the array, write arbitration, read muxes and bypass logic.

Verification
REQ-036 Reset, then release; hold clear_req=0 -> ready=0 for 32 cycles, 1 on cycle 33; read of any address = 0.
REQ-037 Write wb_addr=5, wb_data=0xDEADBEEF, with rd_addr port0=5 in the same cycle -> BYPASS=1: rd_data0=0xDEADBEEF in that cycle. Next cycle, any BYPASS: 0xDEADBEEF.
REQ-038 Same cycle: init_we to addr 7 with 0x11, wb_we to addr 7 with 0x22 -> reg7=0x11; wr_conflict=1 for one cycle.
REQ-039 Write 0xFFFFFFFF to addr 0 -> read addr 0 = 0; bypass also returns 0.
REQ-040 Fill regs 1..31 with nonzero values, then pulse clear_req -> ready=0 for 32 cycles; writes during the sweep are ignored; afterwards all regs read 0.
REQ-041 Assert rst_n=0 at sweep cycle 10 for 2 cycles -> ready stays 0; a full 32-cycle sweep follows release.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared types and default constants for register_file_v3.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    // Default geometry of the register file
    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_NRD    = 2;

    // Sweep controller states
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rf_clear_seq
//  Description : CLEAR/READY controller. Walks every address once, writing zero
//                to each, after reset or on request, then reports ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

    // State and sweep counter registers; reset lands in CLEAR at index 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next state: sweep to the last index, then sit in READY until a clear request
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = READY;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + ADDR_W'(1);
                end
            end
            READY: begin
                if (clear_req) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    // Outputs: the sweep write is active for every CLEAR cycle
    always_comb begin
        ready    = (state_q == READY);
        clr_we   = (state_q == CLEAR);
        clr_addr = clr_idx_q;
    end

endmodule : rf_clear_seq
`default_nettype wire

// File: rtl/register_file_v3.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_v3
//  Description : Multi-read-port register file with init/write-back arbitration,
//                optional hard-wired zero register, optional write bypass and a
//                self-clearing sweep after reset or on request.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_v3
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NRD      = RF_NRD,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  ready,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  init_we,
    input  logic [ADDR_W-1:0]     init_addr,
    input  logic [DATA_W-1:0]     init_data,
    input  logic                  wb_we,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  wr_conflict
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    // Winning write for this cycle (sweep, init or write-back)
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              byp_en;

    logic              conflict_q, conflict_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_req (clear_req),
        .ready     (ready),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // Write arbitration: sweep owns the array in CLEAR; otherwise init beats
    // write-back. Writes to register 0 are dropped when it is hard-wired.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
        end else if (init_we) begin
            wr_en   = !(ZERO_REG && (init_addr == '0));
            wr_addr = init_addr;
            wr_data = init_data;
        end else if (wb_we) begin
            wr_en   = !(ZERO_REG && (wb_addr == '0));
            wr_addr = wb_addr;
            wr_data = wb_data;
        end
        // Only host writes are forwarded; the sweep never reaches the read path
        byp_en = wr_en && ready && BYPASS;
    end

    // Array storage; contents are not reset, the sweep zeroes them instead
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // A dropped write-back is flagged one cycle later
    always_comb begin
        conflict_d = ready && init_we && wb_we;
    end

    // Conflict pulse register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign wr_conflict = conflict_q;

    // Independent combinational read ports
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_k;
        logic [DATA_W-1:0] data_k;

        assign addr_k = rd_addr[k*ADDR_W +: ADDR_W];

        // Read mux: zero while sweeping or for the hard-wired register, else
        // forwarded write data on an address match, else array content
        always_comb begin
            data_k = mem_q[addr_k];
            if (!ready) begin
                data_k = '0;
            end else if (ZERO_REG && (addr_k == '0)) begin
                data_k = '0;
            end else if (byp_en && (addr_k == wr_addr)) begin
                data_k = wr_data;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data_k;
    end

endmodule : register_file_v3
`default_nettype wire
